// File: rtl/i2c_data_path.sv
// Byte-level SDA data path for an I2C master: shifts TxByte out MSB first on SCL
// falling edges, shifts received bits in on SCL rising edges, and samples the slave ack.
module i2c_data_path (
  input  logic       clock,
  input  logic       Reset,
  input  logic       ClockI2C,
  input  logic       WriteLoad,
  input  logic       ReadorWrite,
  input  logic       ShiftorHold,
  input  logic       Select,
  input  logic       StartStopAck,
  input  logic [7:0] TxByte,
  input  logic       SDAin,
  output logic       SDAout,
  output logic [7:0] RxByte,
  output logic       RxValid,
  output logic       AckError,
  output logic [3:0] BitCount
);

  logic       clock_i2c_d;
  logic [7:0] shift_reg;
  logic [7:0] shift_in;
  logic       pos_strobe;
  logic       neg_strobe;
  logic       can_shift;
  logic       write_shift;
  logic       read_shift;
  logic       ack_sample;
  logic       sda_next;

  // SCL is sampled as data; strobes are one clock wide by construction.
  assign pos_strobe  = ClockI2C & ~clock_i2c_d;
  assign neg_strobe  = ~ClockI2C & clock_i2c_d;
  assign can_shift   = ShiftorHold && (BitCount < 4'd8);
  assign write_shift = neg_strobe && can_shift && !ReadorWrite;
  assign read_shift  = pos_strobe && can_shift && ReadorWrite;
  assign ack_sample  = pos_strobe && !Select && ReadorWrite;
  assign shift_in    = {shift_reg[6:0], SDAin};

  always_comb begin
    sda_next = 1'b1;
    if (!ReadorWrite) begin
      sda_next = Select ? shift_reg[7] : StartStopAck;
    end
  end

  // RxValid is a one-cycle strobe with no back-pressure: the consumer must take
  // RxByte in the cycle RxValid is high; RxByte then holds until the next byte.
  always_ff @(posedge clock) begin
    if (Reset) begin
      clock_i2c_d <= 1'b0;
      shift_reg   <= 8'h00;
      BitCount    <= 4'd0;
      RxByte      <= 8'h00;
      RxValid     <= 1'b0;
      AckError    <= 1'b0;
      SDAout      <= 1'b1;
    end else begin
      clock_i2c_d <= ClockI2C;
      RxValid     <= 1'b0;
      SDAout      <= sda_next;
      if (WriteLoad) begin
        shift_reg <= TxByte;
        BitCount  <= 4'd0;
      end else if (write_shift) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        BitCount  <= BitCount + 4'd1;
      end else if (read_shift) begin
        shift_reg <= shift_in;
        BitCount  <= BitCount + 4'd1;
        if (BitCount == 4'd7) begin
          RxByte  <= shift_in;
          RxValid <= 1'b1;
        end
      end
      if (ack_sample) begin
        AckError <= SDAin;
      end
    end
  end

endmodule

// File: tb/tb_i2c_data_path.sv
// Self-checking bench for i2c_data_path: directed scenarios plus randomized bytes,
// compared against a byte/bit-level reference model.
module tb_i2c_data_path;

  logic       clock = 1'b0;
  logic       Reset;
  logic       ClockI2C;
  logic       WriteLoad;
  logic       ReadorWrite;
  logic       ShiftorHold;
  logic       Select;
  logic       StartStopAck;
  logic [7:0] TxByte;
  logic       SDAin;
  logic       SDAout;
  logic [7:0] RxByte;
  logic       RxValid;
  logic       AckError;
  logic [3:0] BitCount;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_tx;
  int         m_count;
  logic [7:0] m_rx;
  logic       m_ack;
  logic [0:0] exp_q[$];

  i2c_data_path dut (
    .clock(clock), .Reset(Reset), .ClockI2C(ClockI2C), .WriteLoad(WriteLoad),
    .ReadorWrite(ReadorWrite), .ShiftorHold(ShiftorHold), .Select(Select),
    .StartStopAck(StartStopAck), .TxByte(TxByte), .SDAin(SDAin), .SDAout(SDAout),
    .RxByte(RxByte), .RxValid(RxValid), .AckError(AckError), .BitCount(BitCount)
  );

  // Clock and watchdog
  always #4 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Expected SDA drive from the mode inputs; in write mode the line carries the
  // loaded byte's bit number (7 - bits already sent), zero once all are sent.
  function automatic logic exp_sda();
    logic [15:0] t;
    t = {8'h00, m_tx} << m_count;
    if (ReadorWrite) return 1'b1;
    if (Select) return t[7];
    return StartStopAck;
  endfunction

  task automatic model_reset();
    m_tx = 8'h00; m_count = 0; m_rx = 8'h00; m_ack = 1'b0; exp_q.delete();
  endtask

  task automatic set_mode(input logic sel, input logic rw, input logic sh);
    Select = sel; ReadorWrite = rw; ShiftorHold = sh;
    tick();
    if (!(sel && !rw)) chk("mode_sda", SDAout, exp_sda());
  endtask

  task automatic load(input logic [7:0] v);
    TxByte = v; WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
    m_tx = v; m_count = 0; exp_q.delete();
    chk("load_count", BitCount, 0);
    tick();
    chk("load_sda", SDAout, exp_sda());
  endtask

  // One SCL period (1 clock high, 2 low); write data checked two clocks after the fall.
  task automatic write_bit();
    ClockI2C = 1'b1;
    tick();
    ClockI2C = 1'b0;
    tick();
    tick();
    if (ShiftorHold && m_count < 8) m_count++;
    chk("wr_count", BitCount, m_count);
    chk("wr_sda", SDAout, exp_sda());
  endtask

  task automatic read_bit(input logic b);
    logic fire;
    fire = 1'b0;
    SDAin = b; ClockI2C = 1'b1;
    tick();
    if (ShiftorHold && m_count < 8) begin
      exp_q.push_back(b);
      m_count++;
      if (m_count == 8) begin
        for (int i = 0; i < 8; i++) m_rx[7-i] = exp_q[i];
        fire = 1'b1;
      end
    end
    chk("rd_valid", RxValid, fire);
    chk("rd_count", BitCount, m_count);
    chk("rd_rxbyte", RxByte, m_rx);
    ClockI2C = 1'b0;
    tick();
    chk("rd_valid_pulse", RxValid, 0);
    tick();
    chk("rd_sda", SDAout, 1);
  endtask

  task automatic ack_bit(input logic b);
    SDAin = b; ClockI2C = 1'b1;
    tick();
    m_ack = b;
    chk("ack_error", AckError, m_ack);
    chk("ack_sda", SDAout, 1);
    chk("ack_count_hold", BitCount, m_count);
    ClockI2C = 1'b0;
    tick();
    tick();
  endtask

  task automatic ssa(input logic v, input logic prev);
    StartStopAck = v;
    #1;
    chk("ssa_latency", SDAout, prev);
    tick();
    chk("ssa_sda", SDAout, v);
  endtask

  initial begin
    logic [7:0] rd_pat;
    Reset = 1'b1; ClockI2C = 1'b0; WriteLoad = 1'b0; ReadorWrite = 1'b0;
    ShiftorHold = 1'b0; Select = 1'b0; StartStopAck = 1'b1; TxByte = 8'h00; SDAin = 1'b1;
    model_reset();
    #6 Reset = 1'b0;
    tick();
    chk("reset_sda", SDAout, 1);
    chk("reset_valid", RxValid, 0);
    chk("reset_count", BitCount, 0);
    chk("reset_ack", AckError, 0);
    chk("reset_rxbyte", RxByte, 0);

    // Write 8'hA5, then a ninth falling edge that must be ignored
    set_mode(1'b1, 1'b0, 1'b1);
    load(8'hA5);
    for (int i = 0; i < 9; i++) write_bit();

    // Read 8'hCA, then one extra rising edge that must be ignored
    set_mode(1'b1, 1'b1, 1'b1);
    load(8'h5E);
    rd_pat = 8'hCA;
    for (int i = 7; i >= 0; i--) read_bit(rd_pat[i]);
    chk("rd_byte_ca", RxByte, 8'hCA);
    read_bit(1'b1);

    // Ack phase
    set_mode(1'b0, 1'b1, 1'b0);
    ack_bit(1'b1);
    ack_bit(1'b0);

    // Start / stop levels
    StartStopAck = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0);
    ssa(1'b0, 1'b1);
    ssa(1'b1, 1'b0);

    // Reset in the middle of a write
    set_mode(1'b0, 1'b1, 1'b0);
    ack_bit(1'b1);
    set_mode(1'b1, 1'b0, 1'b1);
    load(8'h3C);
    for (int i = 0; i < 4; i++) write_bit();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_reset();
    chk("mid_reset_sda", SDAout, 1);
    chk("mid_reset_count", BitCount, 0);
    chk("mid_reset_rxbyte", RxByte, 0);
    chk("mid_reset_valid", RxValid, 0);
    chk("mid_reset_ack", AckError, 0);
    load(8'hFF);
    for (int i = 0; i < 8; i++) write_bit();

    // Load coincident with an SCL falling edge
    ClockI2C = 1'b1;
    tick();
    ClockI2C = 1'b0; TxByte = 8'h96; WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
    m_tx = 8'h96; m_count = 0; exp_q.delete();
    chk("coinc_count", BitCount, 0);
    tick();
    chk("coinc_sda", SDAout, exp_sda());
    write_bit();

    // Randomized rounds with random hold cycles
    for (int r = 0; r < 4; r++) begin
      set_mode(1'b1, 1'b0, 1'b1);
      load(8'($urandom_range(0, 255)));
      for (int i = 0; i < 12; i++) begin
        ShiftorHold = ($urandom_range(0, 3) != 0);
        write_bit();
      end
      set_mode(1'b1, 1'b1, 1'b1);
      load(8'($urandom_range(0, 255)));
      for (int i = 0; i < 12; i++) begin
        ShiftorHold = ($urandom_range(0, 3) != 0);
        read_bit(1'($urandom_range(0, 1)));
      end
      set_mode(1'b0, 1'b1, 1'b0);
      ack_bit(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_data_path.md
I2C_DATA_PATH -- requirements
Module: i2c_data_path

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clock and Reset.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 ClockI2C  input  1  SCL level from the I2C clock generator, synchronous to clock; sampled, never used as a clock.
REQ-005 WriteLoad  input  1  load TxByte into the shift register.
REQ-006 ReadorWrite  input  1  1 = read from the slave; SDA is released and sampled. 0 = write; SDA is driven from the shift register.
REQ-007 ShiftorHold  input  1  1 = shift on the qualifying SCL edge; 0 = hold.
REQ-008 Select  input  1  1 = data-bit path to SDA; 0 = StartStopAck path.
REQ-009 StartStopAck  input  1  SDA value for start, stop and master ack when Select=0 and ReadorWrite=0.
REQ-010 TxByte  input  8  byte to transmit, MSB first.
REQ-011 SDAin  input  1  sampled SDA pin level.
REQ-012 SDAout  output  1  SDA drive; 1 = released (high), 0 = pull low.
REQ-013 RxByte  output  8  last fully received byte.
REQ-014 RxValid  output  1  one-cycle pulse when RxByte updates.
REQ-015 AckError  output  1  1 = the slave did not acknowledge at the last ack sample.
REQ-016 BitCount  output  4  bits shifted since the last load or byte completion, range 0..8.

Function
REQ-017 The block SHALL register ClockI2C once (ClockI2C_d).
REQ-018 The block SHALL define the following edge strobes:
- posedge strobe: ClockI2C & ~ClockI2C_d
- negedge strobe: ~ClockI2C & ClockI2C_d
Each strobe is exactly one clock cycle wide.
REQ-019 WriteLoad=1 SHALL set ShiftReg<=TxByte and BitCount<=0 in that cycle. WriteLoad has priority over any simultaneous shift or sample.
REQ-020 Write shift: on the negedge strobe with ShiftorHold=1, ReadorWrite=0 and BitCount<8, ShiftReg<={ShiftReg[6:0],0} and BitCount increments.
REQ-021 Read shift: on the posedge strobe with ShiftorHold=1, ReadorWrite=1 and BitCount<8, ShiftReg<={ShiftReg[6:0],SDAin} and BitCount increments.
REQ-022 On the read shift that takes BitCount from 7 to 8, RxByte SHALL take the new shift value in the same edge, and RxValid SHALL be 1 for exactly the following cycle.
REQ-023 When BitCount=8, further shift strobes SHALL be ignored; BitCount holds at 8 until WriteLoad or Reset.
REQ-024 Any strobe arriving while ShiftorHold=0 SHALL leave ShiftReg and BitCount unchanged.
REQ-025 SDAout SHALL be registered; its next value is selected as follows:
- Select=1, ReadorWrite=0: ShiftReg[7]
- Select=1, ReadorWrite=1: 1
- Select=0, ReadorWrite=0: StartStopAck
- Select=0, ReadorWrite=1: 1 (releases the bus for the slave ack)
REQ-026 Ack sample: on the posedge strobe with Select=0 and ReadorWrite=1, AckError<=SDAin. AckError otherwise holds and is not cleared by WriteLoad.
REQ-027 Latency:
- SDAout follows its select inputs one clock after they change.
- Write data changes on SDA one clock after the SCL falling edge is detected, which is two clocks after ClockI2C falls.

Reset
REQ-028 Reset=1 at a clock edge SHALL set the following, regardless of any operation in progress:
- SDAout=1
- ShiftReg=0, RxByte=0, BitCount=0
- RxValid=0, AckError=0
- ClockI2C_d=0
REQ-029 After Reset deasserts, the first strobe SHALL be detected from the first ClockI2C transition after reset; a ClockI2C already high at release produces one posedge strobe.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, using clock period 8 ns and ClockI2C period 24 ns:
- Reset held for 6 ns, then idle -> SDAout=1, RxValid=0, BitCount=0, AckError=0.
- WriteLoad with TxByte=8'hA5, then 8 write shifts with Select=1, ReadorWrite=0 -> SDAout sequence 1,0,1,0,0,1,0,1, each valid two clocks after ClockI2C falls; BitCount ends at 8; a 9th negedge leaves it at 8.
- Read mode with SDAin driven 1,1,0,0,1,0,1,0 at 8 posedges -> RxByte=8'hCA, one-cycle RxValid, BitCount=8.
- Ack phase (Select=0, ReadorWrite=1): SDAin=1 at posedge -> AckError=1 and SDAout=1. Next ack with SDAin=0 -> AckError=0.
- Start/stop: Select=0, ReadorWrite=0, StartStopAck toggled 1->0->1 -> SDAout tracks with one-clock latency.
- Reset asserted after 4 write shifts of 8'h3C -> all outputs return to reset values. A new WriteLoad of 8'hFF then shifts cleanly from BitCount=0.
- WriteLoad coincident with a negedge strobe -> load wins, BitCount=0, ShiftReg=TxByte.
